// File: rtl/hex_counter_ctrl.sv
// rtl/hex_counter_ctrl.sv - two-digit debounced push-button counter feeding the hex decoders
// Optional feature: define BCD_MODE_EN for decimal digits (00..99); default is plain hex (00..FF).

module hex_counter_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw,
  output logic step
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t        state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          step_q;
  logic          s;

  assign s    = sync_q[1];
  assign step = step_q;

  // The step request is a registered one-cycle pulse on the PRESS_WAIT -> PRESSED edge only,
  // so a held button never repeats.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      step_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            step_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

module hex_counter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] digit_lo,
  output logic [3:0] digit_hi,
  output logic       upd,
  output logic       wrap
);

  logic       inc_req;
  logic       dec_req;
  logic [7:0] count_q, count_d;
  logic       upd_q, upd_d;
  logic       wrap_q, wrap_d;
  logic [7:0] load_fmt;
  logic [3:0] lo, hi;

  hex_counter_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk     (clk),
    .resetn  (resetn),
    .btn_raw (btn_inc),
    .step    (inc_req)
  );

  hex_counter_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk     (clk),
    .resetn  (resetn),
    .btn_raw (btn_dec),
    .step    (dec_req)
  );

  assign lo = count_q[3:0];
  assign hi = count_q[7:4];

`ifdef BCD_MODE_EN
  assign load_fmt = {(load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4],
                     (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0]};
`else
  assign load_fmt = load_val;
`endif

  always_comb begin
    count_d = count_q;
    upd_d   = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_fmt;
      upd_d   = (load_fmt != count_q);
    end else if (inc_req && !dec_req) begin
      upd_d = 1'b1;
`ifdef BCD_MODE_EN
      if (lo == 4'd9) begin
        count_d = {(hi == 4'd9) ? 4'd0 : hi + 4'd1, 4'd0};
      end else begin
        count_d = {hi, lo + 4'd1};
      end
      wrap_d = (count_q == 8'h99);
`else
      count_d = count_q + 8'd1;
      wrap_d  = (count_q == 8'hFF);
`endif
    end else if (dec_req && !inc_req) begin
      upd_d = 1'b1;
`ifdef BCD_MODE_EN
      if (lo == 4'd0) begin
        count_d = {(hi == 4'd0) ? 4'd9 : hi - 4'd1, 4'd9};
      end else begin
        count_d = {hi, lo - 4'd1};
      end
`else
      count_d = count_q - 8'd1;
`endif
      wrap_d = (count_q == 8'h00);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= 8'h00;
      upd_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      upd_q   <= upd_d;
      wrap_q  <= wrap_d;
    end
  end

  assign digit_lo = count_q[3:0];
  assign digit_hi = count_q[7:4];
  assign upd      = upd_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_hex_counter_ctrl.sv
// tb/tb_hex_counter_ctrl.sv - scoreboard bench for hex_counter_ctrl with DEBOUNCE_CYCLES=4
// Expected count changes are queued by the stimulus and consumed by a monitor on each upd pulse.

module tb_hex_counter_ctrl;

  localparam int D   = 4;
  localparam int LAT = D + 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic       btn_inc, btn_dec, load;
  logic [7:0] load_val;
  logic [3:0] digit_lo, digit_hi;
  logic       upd, wrap;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    logic       wrap;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] prev = 8'h00;
  logic [7:0] cur;

  hex_counter_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .load     (load),
    .load_val (load_val),
    .digit_lo (digit_lo),
    .digit_hi (digit_hi),
    .upd      (upd),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int c, input logic [7:0] v, input logic w);
    exp_t e;
    e.cyc  = c;
    e.val  = v;
    e.wrap = w;
    sb.push_back(e);
  endtask

  task automatic do_load(input logic [7:0] v, input logic [7:0] shown);
    load     = 1'b1;
    load_val = v;
    expect_at(cyc + 1, shown, 1'b0);
    tick(1);
    load = 1'b0;
  endtask

  // which: 0 = inc, 1 = dec
  task automatic clean_press(input int which, input logic [7:0] v, input logic w);
    expect_at(cyc + LAT, v, w);
    if (which == 0) btn_inc = 1'b1; else btn_dec = 1'b1;
    tick(12);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick(12);
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      prev = {digit_hi, digit_lo};
    end else begin
      if (upd) begin
        if (sb.size() == 0) begin
          check("unexpected_upd", {digit_hi, digit_lo}, prev);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("upd_cycle", cyc, e.cyc);
          check("upd_count", {digit_hi, digit_lo}, e.val);
          check("upd_wrap", wrap, e.wrap);
        end
      end else begin
        check("hold_count", {digit_hi, digit_lo}, prev);
        check("wrap_without_upd", wrap, 0);
      end
      prev = {digit_hi, digit_lo};
    end
  end

  initial begin
    resetn   = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;

    tick(3);
    check("reset_digits", {digit_hi, digit_lo}, 8'h00);
    check("reset_upd", upd, 0);
    check("reset_wrap", wrap, 0);
    btn_inc = 1'b1;
    tick(6);
    check("reset_hold_btn_digits", {digit_hi, digit_lo}, 8'h00);
    check("reset_hold_btn_upd", upd, 0);

    // button held through reset deassertion counts once
    resetn = 1'b1;
    expect_at(cyc + LAT, 8'h01, 1'b0);
    tick(20);
    btn_inc = 1'b0;
    tick(12);

    // clean press held 20 cycles
    expect_at(cyc + LAT, 8'h02, 1'b0);
    btn_inc = 1'b1;
    tick(20);
    btn_inc = 1'b0;
    tick(12);

    // bouncing press then bouncing release
    for (int i = 0; i < 3; i++) begin
      btn_inc = 1'b1; tick(2);
      btn_inc = 1'b0; tick(2);
    end
    expect_at(cyc + LAT, 8'h03, 1'b0);
    btn_inc = 1'b1;
    tick(10);
    for (int i = 0; i < 3; i++) begin
      btn_inc = 1'b0; tick(2);
      btn_inc = 1'b1; tick(2);
    end
    btn_inc = 1'b0;
    tick(12);
    check("after_bounce", {digit_hi, digit_lo}, 8'h03);

`ifdef BCD_MODE_EN
    do_load(8'h99, 8'h99);
    clean_press(0, 8'h00, 1'b1);
    do_load(8'h10, 8'h10);
    clean_press(1, 8'h09, 1'b0);
    do_load(8'hA5, 8'h95);
    clean_press(0, 8'h96, 1'b0);
    cur = 8'h96;
`else
    do_load(8'hFF, 8'hFF);
    clean_press(0, 8'h00, 1'b1);
    clean_press(1, 8'hFF, 1'b1);
    do_load(8'h0F, 8'h0F);
    clean_press(0, 8'h10, 1'b0);
    cur = 8'h10;
`endif

    // simultaneous inc and dec requests cancel
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    tick(12);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick(12);
    check("inc_dec_same_cycle", {digit_hi, digit_lo}, cur);

    // load wins over an inc step in the same cycle
    btn_inc = 1'b1;
    tick(LAT - 1);
    load     = 1'b1;
    load_val = 8'h42;
    expect_at(cyc + 1, 8'h42, 1'b0);
    tick(1);
    load = 1'b0;
    tick(12);
    btn_inc = 1'b0;
    tick(12);
    check("load_over_inc", {digit_hi, digit_lo}, 8'h42);

    // reset mid-debounce (PRESS_WAIT, cnt=2) drops the pending step
    do_load(8'h37, 8'h37);
    btn_inc = 1'b1;
    tick(4);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_digits", {digit_hi, digit_lo}, 8'h00);
    check("async_reset_upd", upd, 0);
    check("async_reset_wrap", wrap, 0);
    tick(2);
    btn_inc = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(15);
    check("after_reset_count", {digit_hi, digit_lo}, 8'h00);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
